// File: rtl/unsigned_seq_div_16by8.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per clock,
// valid/ready handshake on the operand and result sides.
module unsigned_seq_div_16by8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] sh_q, sh_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  lo_q, lo_d;
  logic                  dz_q, dz_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. r < divisor keeps t within 9 bits.
  logic [DIVISOR_W:0]    t;
  logic                  qbit;
  logic [DIVISOR_W:0]    r_step;
  logic [DIVIDEND_W-1:0] sh_step;

  always_comb begin
    t       = {r_q[DIVISOR_W-1:0], sh_q[DIVIDEND_W-1]};
    qbit    = (t >= {1'b0, dvs_q});
    r_step  = qbit ? (t - {1'b0, dvs_q}) : t;
    sh_step = {sh_q[DIVIDEND_W-2:0], qbit};
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_BUSY;
          sh_d    = dividend;
          dvs_d   = divisor;
          lo_d    = dividend[DIVISOR_W-1:0];
          dz_d    = (divisor == '0);
          r_d     = '0;
          cnt_d   = '0;
        end
      end

      S_BUSY: begin
        sh_d  = sh_step;
        r_d   = r_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          quo_d   = dz_q ? '1   : sh_step;
          rem_d   = dz_q ? lo_q : r_step[DIVISOR_W-1:0];
          dbz_d   = dz_q;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
